// File: rtl/ir_beam_emitter.sv
// IR beam-break transmitter: emits carrier-modulated burst/gap frames while armed
// and raises beam_broken_o after MISS_LIMIT consecutive frames without an echo.
module ir_beam_emitter #(
  parameter int HALF_PERIOD  = 658,
  parameter int BURST_CYCLES = 20,
  parameter int GAP_CYCLES   = 20,
  parameter int MISS_LIMIT   = 3
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic system_armed_i,
  input  logic ir_echo_i,
  output logic ir_led_o,
  output logic burst_active_o,
  output logic frame_strobe_o,
  output logic beam_broken_o
);

  // state   | meaning
  // S_IDLE  | disarmed, LED off, miss history cleared
  // S_BURST | LED toggles every HALF_PERIOD clks, echo window open
  // S_GAP   | LED off, echo window open, last cycle evaluates the frame

  localparam int BURST_LEN = 2 * HALF_PERIOD * BURST_CYCLES;
  localparam int GAP_LEN   = 2 * HALF_PERIOD * GAP_CYCLES;
  localparam int CNT_MAX   = ((BURST_LEN > GAP_LEN) ? BURST_LEN : GAP_LEN) - 1;
  localparam int CNT_W     = (CNT_MAX > 0) ? $clog2(CNT_MAX + 1) : 1;
  localparam int HP_W      = (HALF_PERIOD > 1) ? $clog2(HALF_PERIOD) : 1;
  localparam int MISS_W    = (MISS_LIMIT > 1) ? $clog2(MISS_LIMIT + 1) : 1;

  localparam logic [CNT_W-1:0]  BURST_LOAD = CNT_W'(BURST_LEN - 1);
  localparam logic [CNT_W-1:0]  GAP_LOAD   = CNT_W'(GAP_LEN - 1);
  localparam logic [HP_W-1:0]   HP_LOAD    = HP_W'(HALF_PERIOD - 1);
  localparam logic [MISS_W-1:0] MISS_MAX   = MISS_W'(MISS_LIMIT);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_BURST = 2'd1,
    S_GAP   = 2'd2
  } state_t;

  state_t            state_q;
  logic [CNT_W-1:0]  cnt_q;
  logic [HP_W-1:0]   hp_q;
  logic [MISS_W-1:0] miss_q;
  logic [MISS_W-1:0] miss_d;
  logic              sync1_q, sync2_q;
  logic              echo_seen_q;
  logic              echo_acc;
  logic              led_q, burst_q, strobe_q, beam_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
    end else begin
      sync1_q <= ir_echo_i;
      sync2_q <= sync1_q;
    end
  end

  // A synchronised echo on the strobe cycle still counts for the closing frame.
  assign echo_acc = echo_seen_q | sync2_q;

  always_comb begin
    miss_d = miss_q;
    if (echo_acc)
      miss_d = '0;
    else if (miss_q != MISS_MAX)
      miss_d = miss_q + 1'b1;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      hp_q        <= '0;
      miss_q      <= '0;
      echo_seen_q <= 1'b0;
      led_q       <= 1'b0;
      burst_q     <= 1'b0;
      strobe_q    <= 1'b0;
      beam_q      <= 1'b0;
    end else if (!system_armed_i) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      hp_q        <= '0;
      miss_q      <= '0;
      echo_seen_q <= 1'b0;
      led_q       <= 1'b0;
      burst_q     <= 1'b0;
      strobe_q    <= 1'b0;
      beam_q      <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          state_q     <= S_BURST;
          cnt_q       <= BURST_LOAD;
          hp_q        <= HP_LOAD;
          echo_seen_q <= 1'b0;
          led_q       <= 1'b1;
          burst_q     <= 1'b1;
          strobe_q    <= 1'b0;
        end
        S_BURST: begin
          echo_seen_q <= echo_acc;
          if (hp_q == '0) begin
            led_q <= ~led_q;
            hp_q  <= HP_LOAD;
          end else begin
            hp_q <= hp_q - 1'b1;
          end
          if (cnt_q == '0) begin
            state_q  <= S_GAP;
            cnt_q    <= GAP_LOAD;
            led_q    <= 1'b0;
            burst_q  <= 1'b0;
            strobe_q <= (GAP_LOAD == '0);
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        S_GAP: begin
          if (cnt_q == '0) begin
            miss_q      <= miss_d;
            beam_q      <= (miss_d == MISS_MAX);
            state_q     <= S_BURST;
            cnt_q       <= BURST_LOAD;
            hp_q        <= HP_LOAD;
            echo_seen_q <= 1'b0;
            led_q       <= 1'b1;
            burst_q     <= 1'b1;
            strobe_q    <= 1'b0;
          end else begin
            echo_seen_q <= echo_acc;
            cnt_q       <= cnt_q - 1'b1;
            strobe_q    <= (cnt_q == CNT_W'(1));
          end
        end
        default: begin
          state_q  <= S_IDLE;
          led_q    <= 1'b0;
          burst_q  <= 1'b0;
          strobe_q <= 1'b0;
        end
      endcase
    end
  end

  assign ir_led_o       = led_q;
  assign burst_active_o = burst_q;
  assign frame_strobe_o = strobe_q;
  assign beam_broken_o  = beam_q;

endmodule

// File: tb/tb_ir_beam_emitter.sv
// Bench for ir_beam_emitter: frame-position reference model checked every cycle,
// directed scenarios with literal expectations, then randomized arming/echo traffic.
module tb_ir_beam_emitter;

  localparam int HP    = 2;
  localparam int BC    = 3;
  localparam int GC    = 2;
  localparam int ML    = 3;
  localparam int BLEN  = 2 * HP * BC;
  localparam int FRAME = 2 * HP * (BC + GC);

  logic clk = 1'b0;
  logic rst, armed, echo;
  logic ir_led, burst, strobe, beam;

  int total = 0;
  int bad   = 0;

  logic [19:0] pat = 20'b1100_1100_1100_0000_0000;

  ir_beam_emitter #(
    .HALF_PERIOD (HP),
    .BURST_CYCLES(BC),
    .GAP_CYCLES  (GC),
    .MISS_LIMIT  (ML)
  ) dut (
    .clk_i         (clk),
    .rst_i         (rst),
    .system_armed_i(armed),
    .ir_echo_i     (echo),
    .ir_led_o      (ir_led),
    .burst_active_o(burst),
    .frame_strobe_o(strobe),
    .beam_broken_o (beam)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic act, input logic exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %b expected %b at t=%0t", name, act, exp, $time);
    end
  endtask

  // Reference model: running flag, position within the 20-clk frame, miss count.
  // The receiver's echo reaches the frame logic two clocks after it is sampled.
  bit m_run, m_seen, m_d1, m_d2, m_eff;
  int m_pos, m_miss;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_run = 0; m_seen = 0; m_d1 = 0; m_d2 = 0; m_pos = 0; m_miss = 0;
    end else begin
      m_eff = m_d2;
      m_d2  = m_d1;
      m_d1  = echo;
      if (!armed) begin
        m_run = 0; m_miss = 0; m_seen = 0;
      end else if (!m_run) begin
        m_run = 1; m_pos = 0; m_seen = 0;
      end else if (m_pos == FRAME - 1) begin
        if (m_seen || m_eff) m_miss = 0;
        else if (m_miss < ML) m_miss++;
        m_seen = 0;
        m_pos  = 0;
      end else begin
        m_seen = m_seen || m_eff;
        m_pos++;
      end
    end
  end

  always @(negedge clk) begin
    check("led",    ir_led, m_run && (m_pos < BLEN) && (((m_pos / HP) % 2) == 0));
    check("burst",  burst,  m_run && (m_pos < BLEN));
    check("strobe", strobe, m_run && (m_pos == FRAME - 1));
    check("beam",   beam,   m_miss == ML);
  end

  initial begin
    rst = 1'b1; armed = 1'b0; echo = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_led", ir_led, 1'b0);
    check("rst_burst", burst, 1'b0);
    check("rst_strobe", strobe, 1'b0);
    check("rst_beam", beam, 1'b0);
    rst = 1'b0;
    @(negedge clk);
    check("idle_led", ir_led, 1'b0);

    // Echo always present: fixed LED pattern, strobe every 20 clk, never broken.
    echo = 1'b1; armed = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 60; i++) begin
      check("pat_led", ir_led, pat[19 - (i % 20)]);
      check("pat_strobe", strobe, (i % 20) == 19);
      check("pat_beam", beam, 1'b0);
      @(negedge clk);
    end

    // Disarm at burst clock 5: LED drops next clock and no strobe follows.
    repeat (5) @(negedge clk);
    armed = 1'b0; echo = 1'b0;
    @(negedge clk);
    check("disarm_led", ir_led, 1'b0);
    check("disarm_burst", burst, 1'b0);
    for (int i = 0; i < 24; i++) begin
      check("disarm_no_strobe", strobe, 1'b0);
      @(negedge clk);
    end

    // Re-arm with no echo: fresh frame, beam_broken after the 3rd strobe and held.
    armed = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 120; i++) begin
      check("miss_led", ir_led, pat[19 - (i % 20)]);
      check("miss_beam", beam, i >= 60);
      @(negedge clk);
    end

    // One-clock echo mid-gap clears beam_broken after that frame's strobe.
    repeat (14) @(negedge clk);
    echo = 1'b1;
    @(negedge clk);
    echo = 1'b0;
    repeat (4) @(negedge clk);
    check("gap_echo_before", beam, 1'b1);
    @(negedge clk);
    check("gap_echo_after", beam, 1'b0);

    // Two misses, then an echo pulse timed so the synchronised echo lands on the
    // strobe cycle; it must reset the miss count for the closing frame.
    repeat (40) @(negedge clk);
    check("two_miss_beam", beam, 1'b0);
    repeat (17) @(negedge clk);
    echo = 1'b1;
    @(negedge clk);
    echo = 1'b0;
    @(negedge clk);
    check("late_echo_strobe", strobe, 1'b1);
    @(negedge clk);
    check("late_echo_counted", beam, 1'b0);
    repeat (40) @(negedge clk);
    check("after_late_two_miss", beam, 1'b0);
    repeat (20) @(negedge clk);
    check("after_late_three_miss", beam, 1'b1);

    // Asynchronous reset in the middle of a burst.
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check("async_led", ir_led, 1'b0);
    check("async_burst", burst, 1'b0);
    check("async_strobe", strobe, 1'b0);
    check("async_beam", beam, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    check("post_rst_idle", burst, 1'b0);
    @(negedge clk);
    check("post_rst_burst_high", ir_led, 1'b1);

    // Randomized traffic with varying echo density and occasional disarms.
    for (int ep = 0; ep < 16; ep++) begin
      int p;
      case (ep % 4)
        0: p = 0;
        1: p = 2;
        2: p = 10;
        default: p = 50;
      endcase
      for (int c = 0; c < 200; c++) begin
        @(negedge clk);
        echo  = ($urandom_range(0, 99) < p);
        armed = ($urandom_range(0, 299) != 0);
      end
    end

    @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
